// File: rtl/mem_bus_pkg.sv
// Shared types and default sizes for the line-wide memory bus initiator.
package mem_bus_pkg;

  localparam int DEF_MEM_ADDR_SIZE     = 19;
  localparam int DEF_CACHE_LINE_SIZE   = 16;
  localparam int DEF_CACHE_OFFSET_SIZE = 4;
  localparam int DEF_TIMEOUT_CYCLES    = 255;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_RESP  = 2'd1,
    CMD_READ  = 2'd2,
    CMD_WRITE = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_timer.sv
// Clearable saturating WAIT-cycle counter; expired flags the last allowed cycle.
module mem_bus_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int W              = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: issues one line read/write on the shared tristate bus and
// returns the responder's completion (or a timeout error) to the cache.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int MEM_ADDR_SIZE     = DEF_MEM_ADDR_SIZE,
  parameter int CACHE_LINE_SIZE   = DEF_CACHE_LINE_SIZE,
  parameter int CACHE_OFFSET_SIZE = DEF_CACHE_OFFSET_SIZE,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [MEM_ADDR_SIZE-1:0]     req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
  output logic                         resp_valid,
  output logic                         resp_error,
  output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
  inout  wire  [MEM_ADDR_SIZE-1:0]     address,
  inout  wire  [CACHE_LINE_SIZE*8-1:0] data,
  inout  wire  [1:0]                   command
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam logic [MEM_ADDR_SIZE-1:0] OFFSET_MASK =
    MEM_ADDR_SIZE'((1 << CACHE_OFFSET_SIZE) - 1);

  state_e                   state, next_state;
  logic                     write_q;
  logic [MEM_ADDR_SIZE-1:0] addr_q;
  logic [LINE_W-1:0]        wdata_q;
  logic                     cmd_en, data_en;
  logic                     accept, got_resp, timer_expired;

  assign accept   = (state == IDLE) && req_valid;
  // An X/Z command compares unknown and is treated as "no response".
  assign got_resp = (state == WAIT) && (command == CMD_RESP);

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = DRIVE;
      end
      DRIVE: next_state = WAIT;
      WAIT:  if (got_resp || timer_expired) next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cmd_en     <= 1'b0;
      data_en    <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state   <= next_state;
      // Enables are high exactly during the DRIVE cycle that follows an accept.
      cmd_en  <= accept;
      data_en <= accept && req_write;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr & ~OFFSET_MASK;
        wdata_q <= req_wdata;
      end
      if ((state == WAIT) && (next_state == RESP)) begin
        resp_error <= !got_resp;
        if (got_resp && !write_q) resp_rdata <= data;
      end
    end
  end

  mem_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == DRIVE),
    .enable (state == WAIT),
    .expired(timer_expired)
  );

  assign command = cmd_en  ? (write_q ? CMD_WRITE : CMD_READ) : 2'bzz;
  assign address = cmd_en  ? addr_q  : {MEM_ADDR_SIZE{1'bz}};
  assign data    = data_en ? wdata_q : {LINE_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a small responder and a line-level model.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int AW = 19;
  localparam int LW = 128;
  localparam int TO = 255;
  localparam logic [AW-1:0] PROBE_A = 19'h2A5A5;
  localparam logic [LW-1:0] PROBE_D = {16{8'h5A}};

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid, resp_error;
  logic [LW-1:0] resp_rdata;
  wire  [AW-1:0] address;
  wire  [LW-1:0] data;
  wire  [1:0]    command;

  // Responder-side bus drivers
  logic          tb_cmd_en, tb_addr_en, tb_data_en;
  logic [1:0]    tb_cmd;
  logic [AW-1:0] tb_addr;
  logic [LW-1:0] tb_data;

  assign command = tb_cmd_en  ? tb_cmd  : 2'bzz;
  assign address = tb_addr_en ? tb_addr : {AW{1'bz}};
  assign data    = tb_data_en ? tb_data : {LW{1'bz}};

  mem_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_error(resp_error),
    .resp_rdata(resp_rdata),
    .address   (address),
    .data      (data),
    .command   (command)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [LW-1:0] model_rdata;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] ramp;

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    wbyte;
    int            delay;
    logic [1:0]    exp_cmd;
    logic [AW-1:0] exp_addr;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic release_bus();
    tb_cmd_en  = 1'b0;
    tb_addr_en = 1'b0;
    tb_data_en = 1'b0;
  endtask

  // Drive a recognisable pattern; it reads back intact only if the DUT is off the bus.
  task automatic probe_bus(output bit ok);
    tb_cmd     = CMD_NOP;
    tb_addr    = PROBE_A;
    tb_data    = PROBE_D;
    tb_cmd_en  = 1'b1;
    tb_addr_en = 1'b1;
    tb_data_en = 1'b1;
    #1;
    ok = (command === 2'(CMD_NOP)) && (address === PROBE_A) && (data === PROBE_D);
  endtask

  // delay = WAIT cycle index in which the responder answers; >= TO means never.
  task automatic run_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input int delay, input logic [LW-1:0] rline,
                         input logic [1:0] exp_cmd, input logic [AW-1:0] exp_addr,
                         input logic exp_err);
    int n;
    int last;
    bit ok;
    bit bad_rel;
    bit bad_early;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({name, "_ready_wait"}, req_ready, 1'b1);
      return;
    end
    if (!wr && !exp_err) model_rdata = rline;
    exp_q.push_back(model_rdata);
    last = exp_err ? TO - 1 : delay;

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;

    @(negedge clk);
    check({name, "_drive_ready"}, req_ready, 1'b0);
    check({name, "_drive_cmd"}, command, exp_cmd);
    check({name, "_drive_addr"}, address, exp_addr);
    if (wr) begin
      check({name, "_drive_data"}, data, wdata);
    end else begin
      tb_data    = PROBE_D;
      tb_data_en = 1'b1;
      #1 check({name, "_drive_data_rel"}, data, PROBE_D);
    end
    @(posedge clk);
    #1 release_bus();

    bad_rel   = 1'b0;
    bad_early = 1'b0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (resp_valid || req_ready) bad_early = 1'b1;
      if (k == delay) begin
        tb_cmd    = CMD_RESP;
        tb_data   = rline;
        tb_cmd_en = 1'b1;
        tb_data_en = 1'b1;
      end else begin
        probe_bus(ok);
        if (!ok) bad_rel = 1'b1;
      end
      @(posedge clk);
      #1 release_bus();
    end
    check({name, "_wait_released"}, bad_rel, 1'b0);
    check({name, "_wait_quiet"}, bad_early, 1'b0);

    @(negedge clk);
    check({name, "_resp_valid"}, resp_valid, 1'b1);
    check({name, "_resp_error"}, resp_error, exp_err);
    check({name, "_resp_rdata"}, resp_rdata, exp_q.pop_front());
    @(negedge clk);
    check({name, "_after_ready"}, {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata, rline;
    int            delay, drives, resps, ready_bad;
    bit            pending, ok, seen;

    for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
    vecs[0] = '{"rd_basic",   1'b0, 19'h00120, 8'h00,   3, 2'd2, 19'h00120, 1'b0};
    vecs[1] = '{"wr_basic",   1'b1, 19'h7FFF0, 8'hA5,   2, 2'd3, 19'h7FFF0, 1'b0};
    vecs[2] = '{"rd_offset",  1'b0, 19'h0012F, 8'h00,   0, 2'd2, 19'h00120, 1'b0};
    vecs[3] = '{"rd_timeout", 1'b0, 19'h01234, 8'h00, 300, 2'd2, 19'h01230, 1'b1};
    vecs[4] = '{"rd_tie",     1'b0, 19'h05555, 8'h00, 254, 2'd2, 19'h05550, 1'b0};
    vecs[5] = '{"wr_timeout", 1'b1, 19'h0000F, 8'h3C, 255, 2'd3, 19'h00000, 1'b1};
    vecs[6] = '{"rd_late",    1'b0, 19'h6ABCD, 8'h00, 253, 2'd2, 19'h6ABC0, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tb_cmd    = CMD_NOP;
    tb_addr   = '0;
    tb_data   = '0;
    release_bus();
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_ready", req_ready, 1'b1);
    check("reset_resp", {resp_valid, resp_error}, 2'b00);
    check("reset_rdata", resp_rdata, '0);
    probe_bus(ok);
    check("reset_released", ok, 1'b1);
    release_bus();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, {16{vecs[i].wbyte}}, vecs[i].delay,
              ramp ^ {16{8'(i)}}, vecs[i].exp_cmd, vecs[i].exp_addr, vecs[i].exp_err);
    end

    for (int i = 0; i < 20; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      rline = {$urandom, $urandom, $urandom, $urandom};
      delay = $urandom_range(0, 6);
      run_txn($sformatf("rand%0d", i), wr, addr, wdata, delay, rline,
              wr ? 2'd3 : 2'd2, (addr / 16) * 16, (delay >= TO) ? 1'b1 : 1'b0);
    end

    // req_valid held high across two reads answered immediately
    drives = 0; resps = 0; ready_bad = 0; pending = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 19'h0ABC0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (command === 2'(CMD_READ)) begin
        drives++;
        if (req_ready) ready_bad++;
        pending = 1'b1;
      end else if (pending) begin
        pending = 1'b0;
        if (req_ready) ready_bad++;
        tb_cmd     = CMD_RESP;
        tb_data    = ramp;
        tb_cmd_en  = 1'b1;
        tb_data_en = 1'b1;
        @(posedge clk);
        #1 release_bus();
      end else if (resp_valid) begin
        resps++;
        if (req_ready) ready_bad++;
        if (resps == 2) req_valid = 1'b0;
      end
    end
    model_rdata = ramp;
    check("b2b_drives", drives, 2);
    check("b2b_resps", resps, 2);
    check("b2b_ready_low", ready_bad, 0);
    check("b2b_rdata", resp_rdata, model_rdata);

    // reset during the second WAIT cycle aborts the read
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 19'h00340;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, model_rdata);
    probe_bus(ok);
    check("rst_released", ok, 1'b1);
    tb_cmd  = CMD_RESP;
    tb_data = ramp;
    tb_addr_en = 1'b0;
    @(posedge clk);
    #1 release_bus();
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst_no_resp", seen, 1'b0);
    check("rst_idle_ready", req_ready, 1'b1);

    run_txn("post_rst", 1'b0, 19'h11118, '0, 1, ~ramp, 2'd2, 19'h11110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
